umtrx_rx_arbiter: RTL and testbench
===================================

Name: umtrx_rx_arbiter

Overview:
- Packet-aware round-robin arbiter in the sys clock domain.
- Merges the 36-bit VITA streams leaving NUM_CHAN RX chains into one stream toward the router/ethernet path.
- Grants whole packets only, never interleaving beats, and skips channels masked off via the settings bus.
- Keeps a per-channel count of forwarded packets for debug and overflow accounting.

Parameters:
- NUM_CHAN, 2, number of RX chain inputs (2..4).
- SR_BASE, 0, settings-bus base address for this block's registers.
- EN_INIT, all ones, reset value of the channel-enable mask (width NUM_CHAN).

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous, active-low reset
- set_stb  in  1  settings strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- in_data  in  36*NUM_CHAN  VITA stream per channel; channel k occupies [36k+35:36k]; bit 33 = EOF, bit 32 = SOF
- in_valid  in  NUM_CHAN  per-channel valid
- in_ready  out  NUM_CHAN  per-channel ready
- out_data  out  36  merged stream
- out_valid  out  1  merged valid
- out_ready  in  1  downstream ready
- grant  out  NUM_CHAN  one-hot current grant; zero when idle
- pkt_count  out  32*NUM_CHAN  forwarded packets per channel
- busy  out  1  high while a packet is in flight

Behaviour:
- Reset (asynchronous, sys_rst_n low):
  - state = IDLE, grant = 0, last = NUM_CHAN-1 so channel 0 wins first.
  - en_mask = EN_INIT, pkt_count = 0.
  - out_valid = 0, in_ready = 0, busy = 0.
- Settings register SR_BASE+0, written when set_stb is high and set_addr == SR_BASE:
  - en_mask <= set_data[NUM_CHAN-1:0].
  - If set_data[31] = 1, all pkt_count values clear in the same cycle.
  - Other addresses are ignored.
- FSM, two states:
  - IDLE: candidates = in_valid & en_mask. Pick the first set candidate searching last+1, last+2, … modulo NUM_CHAN. If one exists, register sel and a one-hot grant, then go to PASS. If none, stay in IDLE. One idle bubble cycle between packets is accepted.
  - PASS:
    - out_data = in_data[sel] and out_valid = in_valid[sel] (combinational).
    - in_ready[sel] = out_ready; all other in_ready = 0.
    - On a handshake beat (valid & ready) with EOF = 1: pkt_count[sel] += 1, last <= sel, grant <= 0, go to IDLE.
- Output signals:
  - In IDLE, out_valid = 0 and all in_ready = 0.
  - busy = (state == PASS).
  - Latency is combinational data path in PASS; zero added beats.
- Boundary conditions:
  - Mask cleared for the granted channel mid-packet: the packet completes; the mask affects only the next arbitration.
  - Mask written in the same cycle as an arbitration decision: the decision uses the old mask.
  - All channels masked: the block stays in IDLE and inputs back-pressure.
  - A single-beat packet (SOF and EOF together) is handled like any other EOF beat.
  - The SOF bit is passed through and not checked.
  - pkt_count wraps modulo 2^32.
  - A counter clear in the same cycle as an EOF increment: clear wins, count = 0.
  - out_ready low in PASS holds the stream; no timeout.
  - Reset mid-packet returns to IDLE at once; the partial packet is the upstream FIFO's concern.

Decomposition:
- Shared package holds:
  - VITA flag bit indices: EOF = 33, SOF = 32, occupancy = 35:34.
  - Settings offset constant SR_EN = 0.
  - Clear-bit index 31.
- One sub-module is natural: rr_pick, a combinational round-robin priority encoder with inputs req[NUM_CHAN] and last, and outputs a one-hot gnt and a valid flag. The top holds the FSM, mux, mask and counters.

Test Plan:
- Reset, then ch0 and ch1 both hold 3-beat packets, out_ready = 1 → ch0 packet, one idle cycle, ch1 packet, then ch0 again. pkt_count = {1,1} after the first two packets.
- Only ch1 valid with en_mask = 2'b01 written → no output and in_ready = 0. Write 2'b11 → ch1 packet forwarded, pkt_count[1] = 1.
- ch0 granted on a 4-beat packet, en_mask written to 2'b10 after beat 2 → beats 3–4 of ch0 still forwarded, subsequent grants go only to ch1.
- out_ready toggles 1,0,0,1 during a ch1 packet → no beats lost or duplicated, out_data matches the input sequence, in_ready[0] stays 0 throughout.
- Single-beat packet (SOF = EOF = 1) on ch0 → forwarded in one beat, state back to IDLE the next cycle, pkt_count[0] = 1.
- Write set_data = 0x8000_0003 in the same cycle as a ch0 EOF beat → all counters read 0 the next cycle, en_mask = 2'b11. Separately, sys_rst_n low mid-packet → out_valid and grant go to 0 immediately, and after release arbitration restarts at ch0.

Source files
------------

// File: rtl/umtrx_rx_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : umtrx_rx_arbiter_pkg
// Description : Shared constants and types for the UmTRX RX packet arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package umtrx_rx_arbiter_pkg;

    // VITA 36-bit beat flag positions
    localparam int C_EOF_BIT = 33;
    localparam int C_SOF_BIT = 32;
    localparam int C_OCC_HI  = 35;
    localparam int C_OCC_LO  = 34;

    localparam int C_SR_EN   = 0;
    localparam int C_CLR_BIT = 31;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/umtrx_rx_arbiter_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : umtrx_rx_arbiter_rr_pick
// Description : Combinational round-robin priority encoder; searches from
//               last+1 upward modulo NUM_CHAN.
// Revision    : 1.0 - initial release
// ============================================================================
module umtrx_rx_arbiter_rr_pick #(
    parameter int NUM_CHAN = 2,
    parameter int LW       = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic [NUM_CHAN-1:0] req,
    input  logic [LW-1:0]       last,
    output logic [NUM_CHAN-1:0] gnt,
    output logic [LW-1:0]       idx,
    output logic                valid
);

    logic [LW-1:0] w_cand;

    always_comb begin
        gnt    = '0;
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int i = 1; i <= NUM_CHAN; i++) begin
            w_cand = LW'((int'(last) + i) % NUM_CHAN);
            if (!valid && req[w_cand]) begin
                valid       = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/umtrx_rx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : umtrx_rx_arbiter
// Description : Packet-aware round-robin merge of NUM_CHAN VITA RX streams
//               with settings-bus channel mask and per-channel packet counts.
// Revision    : 1.0 - initial release
// ============================================================================
module umtrx_rx_arbiter
    import umtrx_rx_arbiter_pkg::*;
#(
    parameter int                  NUM_CHAN = 2,
    parameter int                  SR_BASE  = 0,
    parameter logic [NUM_CHAN-1:0] EN_INIT  = {NUM_CHAN{1'b1}}
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     set_stb,
    input  logic [7:0]               set_addr,
    input  logic [31:0]              set_data,
    input  logic [36*NUM_CHAN-1:0]   in_data,
    input  logic [NUM_CHAN-1:0]      in_valid,
    output logic [NUM_CHAN-1:0]      in_ready,
    output logic [35:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CHAN-1:0]      grant,
    output logic [32*NUM_CHAN-1:0]   pkt_count,
    output logic                     busy
);

    localparam int         LW        = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam logic [7:0] C_SR_ADDR = 8'(SR_BASE + C_SR_EN);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [LW-1:0]       r_sel;
    logic [LW-1:0]       r_last;
    logic [NUM_CHAN-1:0] r_grant;
    logic [NUM_CHAN-1:0] r_en_mask;
    logic [31:0]         r_pkt_count [NUM_CHAN];

    logic [35:0]         w_in_data [NUM_CHAN];
    logic [35:0]         w_sel_data;
    logic                w_pass;
    logic                w_eof_beat;
    logic                w_set_hit;
    logic                w_clr;
    logic [NUM_CHAN-1:0] w_pick_gnt;
    logic [LW-1:0]       w_pick_idx;
    logic                w_pick_valid;
    logic                w_unused;

    generate
        for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
            assign w_in_data[k]           = in_data[36*k +: 36];
            assign pkt_count[32*k +: 32]  = r_pkt_count[k];
        end
    endgenerate

    // Arbitration sees the registered mask, so a same-cycle write takes effect next decision
    umtrx_rx_arbiter_rr_pick #(
        .NUM_CHAN (NUM_CHAN),
        .LW       (LW)
    ) u_rr_pick (
        .req   (in_valid & r_en_mask),
        .last  (r_last),
        .gnt   (w_pick_gnt),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    assign w_pass     = (r_state == ST_PASS);
    assign w_sel_data = w_in_data[r_sel];
    assign out_data   = w_sel_data;
    assign out_valid  = w_pass & in_valid[r_sel];
    assign in_ready   = w_pass ? (r_grant & {NUM_CHAN{out_ready}}) : '0;
    assign grant      = r_grant;
    assign busy       = w_pass;
    assign w_eof_beat = out_valid & out_ready & w_sel_data[C_EOF_BIT];
    assign w_set_hit  = set_stb && (set_addr == C_SR_ADDR);
    assign w_clr      = w_set_hit && set_data[C_CLR_BIT];

    assign w_unused   = &{1'b0, set_data[C_CLR_BIT-1:NUM_CHAN],
                          w_sel_data[C_SOF_BIT], w_sel_data[C_OCC_HI:C_OCC_LO]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_valid) w_state_nxt = ST_PASS;
            ST_PASS: if (w_eof_beat)   w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_grant   <= '0;
            r_last    <= LW'(NUM_CHAN - 1);
            r_en_mask <= EN_INIT;
        end else begin
            r_state <= w_state_nxt;
            if (w_set_hit) begin
                r_en_mask <= set_data[NUM_CHAN-1:0];
            end
            if (r_state == ST_IDLE && w_pick_valid) begin
                r_sel   <= w_pick_idx;
                r_grant <= w_pick_gnt;
            end else if (w_eof_beat) begin
                r_last  <= r_sel;
                r_grant <= '0;
            end
        end
    end

    // A clear on the same cycle as an EOF increment wins
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < NUM_CHAN; k++) r_pkt_count[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CHAN; k++) begin
                if (w_clr) begin
                    r_pkt_count[k] <= '0;
                end else if (w_eof_beat && r_sel == LW'(k)) begin
                    r_pkt_count[k] <= r_pkt_count[k] + 32'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_umtrx_rx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_umtrx_rx_arbiter
// Description : Self-checking bench: packet queues per channel and a
//               round-robin packet-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_umtrx_rx_arbiter;

    localparam int N   = 2;
    localparam int SRB = 0;
    localparam int LIM = 3000;

    logic            sys_clk   = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic            set_stb   = 1'b0;
    logic [7:0]      set_addr  = '0;
    logic [31:0]     set_data  = '0;
    logic [36*N-1:0] in_data   = '0;
    logic [N-1:0]    in_valid  = '0;
    logic [N-1:0]    in_ready;
    logic [35:0]     out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N-1:0]    grant;
    logic [32*N-1:0] pkt_count;
    logic            busy;

    always #5 sys_clk = ~sys_clk;

    umtrx_rx_arbiter #(.NUM_CHAN(N), .SR_BASE(SRB), .EN_INIT(2'b11)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [35:0] src_q [N][$];
    int          m_last, m_cur;
    logic [N-1:0] m_mask;
    logic [31:0] m_cnt [N];
    int          order [$];
    int          rdy_pat [$];
    int          rdy_pct = 100;
    int          gap_pct = 0;
    bit          prev_eof = 1'b0;
    bit          clr_on_eof = 1'b0;
    logic [31:0] clr_data = '0;
    bit          wr_now = 1'b0;
    logic [31:0] wr_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_cur  = -1;
        m_mask = '1;
        for (int k = 0; k < N; k++) m_cnt[k] = '0;
        prev_eof = 1'b0;
    endtask

    function automatic int pick();
        for (int i = 1; i <= N; i++) begin
            int c = (m_last + i) % N;
            if (m_mask[c] && src_q[c].size() > 0) return c;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int k = 0; k < N; k++)
            if (m_mask[k] && src_q[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_pkt(input int ch, input int len);
        for (int i = 0; i < len; i++)
            src_q[ch].push_back({2'(i), (i == len - 1), (i == 0), 32'($urandom)});
    endtask

    // One clock: drive at edge+1, check at edge+2, update the model, advance
    task automatic step();
        logic [N-1:0] hs_exp;
        logic [35:0]  exp_beat;
        int           ch;
        bit           hs;
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0) begin
                in_data[36*k +: 36] = src_q[k][0];
                in_valid[k] = src_q[k][0][32] || ($urandom_range(99) >= gap_pct);
            end else begin
                in_data[36*k +: 36] = 36'($urandom);
                in_valid[k] = 1'b0;
            end
        end
        if (rdy_pat.size() > 0) out_ready = (rdy_pat.pop_front() != 0);
        else                    out_ready = ($urandom_range(99) < rdy_pct);
        if (wr_now) begin
            set_stb = 1'b1; set_addr = 8'(SRB); set_data = wr_data;
        end
        #1;
        if (clr_on_eof && out_valid && out_ready && out_data[33]) begin
            set_stb = 1'b1; set_addr = 8'(SRB); set_data = clr_data;
            wr_now = 1'b1; wr_data = clr_data; clr_on_eof = 1'b0;
        end
        chk("ready_only_granted", 64'(in_ready & ~grant), 64'd0);
        if (prev_eof) chk("idle_bubble", {out_valid, busy, grant}, 64'd0);
        hs = out_valid && out_ready;
        hs_exp = '0;
        if (hs) begin
            ch = (m_cur >= 0) ? m_cur : pick();
            if (ch < 0) begin
                chk("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
                if (m_cur < 0) order.push_back(ch);
                exp_beat = src_q[ch][0];
                chk("grant", 64'(grant), 64'(1 << ch));
                chk("data", 64'(out_data), 64'(exp_beat));
                hs_exp[ch] = 1'b1;
                if (exp_beat[33]) begin
                    m_cnt[ch]++; m_last = ch; m_cur = -1;
                end else begin
                    m_cur = ch;
                end
            end
        end
        chk("accept", 64'(in_ready & in_valid), 64'(hs_exp));
        prev_eof = hs && out_data[33];
        for (int k = 0; k < N; k++)
            if (in_ready[k] && in_valid[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (wr_now) begin
            m_mask = wr_data[N-1:0];
            if (wr_data[31]) for (int k = 0; k < N; k++) m_cnt[k] = '0;
            wr_now = 1'b0;
        end
        @(posedge sys_clk);
        #1;
        set_stb = 1'b0;
    endtask

    task automatic write_reg(input logic [31:0] d);
        wr_now = 1'b1; wr_data = d;
        step();
    endtask

    task automatic drain();
        int n = 0;
        while ((pending() || m_cur >= 0) && n < LIM) begin
            step(); n++;
        end
        checks++;
        assert (n < LIM) else begin
            failures++;
            $error("FAIL drain_timeout cycles=%0d limit=%0d", n, LIM);
        end
    endtask

    task automatic chk_counts(input string tag);
        for (int k = 0; k < N; k++) chk(tag, 64'(pkt_count[32*k +: 32]), 64'(m_cnt[k]));
    endtask

    initial begin
        int n;
        model_reset();
        @(posedge sys_clk); #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        sys_rst_n = 1'b1;

        // Two channels with 3-beat packets, always ready
        order.delete();
        add_pkt(0, 3); add_pkt(0, 3); add_pkt(1, 3);
        n = 0;
        while (!(m_cnt[0] >= 1 && m_cnt[1] >= 1) && n < 200) begin step(); n++; end
        chk("cnt0_after_two", 64'(pkt_count[31:0]), 64'd1);
        chk("cnt1_after_two", 64'(pkt_count[63:32]), 64'd1);
        drain();
        chk("order_len", 64'(order.size()), 64'd3);
        if (order.size() == 3) begin
            chk("order0", 64'(order[0]), 64'd0);
            chk("order1", 64'(order[1]), 64'd1);
            chk("order2", 64'(order[2]), 64'd0);
        end

        // ch1 masked off: no output, back-pressure; then enable
        write_reg(32'h8000_0001);
        add_pkt(1, 3);
        repeat (6) step();
        chk("masked_in_ready", 64'(in_ready), 64'd0);
        chk("masked_out_valid", 64'(out_valid), 64'd0);
        write_reg(32'h0000_0003);
        drain();
        chk("cnt1_after_enable", 64'(pkt_count[63:32]), 64'd1);

        // Mask cleared for ch0 mid-packet
        order.delete();
        add_pkt(0, 4); add_pkt(0, 2); add_pkt(1, 2); add_pkt(1, 2);
        n = 0;
        while (src_q[0].size() > 4 && n < 200) begin step(); n++; end
        write_reg(32'h0000_0002);
        drain();
        chk("mask_order_len", 64'(order.size()), 64'd3);
        if (order.size() == 3) begin
            chk("mask_order0", 64'(order[0]), 64'd0);
            chk("mask_order1", 64'(order[1]), 64'd1);
            chk("mask_order2", 64'(order[2]), 64'd1);
        end
        chk("ch0_left_waiting", 64'(src_q[0].size()), 64'd2);
        repeat (3) step();
        src_q[0].delete();
        write_reg(32'h0000_0003);

        // out_ready stalls during a ch1 packet
        order.delete();
        add_pkt(1, 4);
        rdy_pat = '{1, 1, 0, 0, 1, 1, 1, 1};
        drain();
        rdy_pat.delete();
        chk("stall_order", 64'(order[0]), 64'd1);

        // Single-beat packet
        write_reg(32'h8000_0003);
        add_pkt(0, 1);
        drain();
        chk("single_cnt0", 64'(pkt_count[31:0]), 64'd1);
        chk("single_idle_next", 64'(busy), 64'd0);

        // Clear coinciding with an EOF beat; mask re-enabled by the same write
        add_pkt(1, 2);
        drain();
        write_reg(32'h0000_0001);
        add_pkt(0, 3);
        clr_on_eof = 1'b1; clr_data = 32'h8000_0003;
        drain();
        step();
        chk("clr_cnt0", 64'(pkt_count[31:0]), 64'd0);
        chk("clr_cnt1", 64'(pkt_count[63:32]), 64'd0);
        add_pkt(1, 1);
        drain();
        chk("clr_mask_cnt1", 64'(pkt_count[63:32]), 64'd1);

        // Reset in the middle of a ch0 packet
        add_pkt(0, 6);
        repeat (3) step();
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_grant", 64'(grant), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        model_reset();
        while (src_q[0].size() > 0 && !src_q[0][0][32]) void'(src_q[0].pop_front());
        order.delete();
        add_pkt(1, 2); add_pkt(0, 2);
        drain();
        chk("restart_ch0", 64'(order[0]), 64'd0);
        chk_counts("restart_counts");

        // Randomized traffic with stalls and valid gaps
        rdy_pct = 70; gap_pct = 25;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 20; p++) add_pkt(int'($urandom_range(N - 1)), int'($urandom_range(6, 1)));
            drain();
            chk_counts("rand_counts");
        end
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
